// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one native-interface memory/IO target port between
// N_CORES picorv32 requesters using a round-robin pointer. One transaction is
// outstanding at a time; a per-transaction timeout returns a zero response if
// the target never answers.
//
// Handshake: a core holds req_valid with stable addr/wdata/wstrb until it sees
// a one-cycle req_ready pulse. Downstream, m_valid stays high with stable
// m_addr/m_wdata/m_wstrb until m_ready is seen high at a clock edge (single-cycle
// accept/complete); m_ready while m_valid is low is ignored.
module mem_rr_arbiter #(
    parameter int N_CORES  = 4,
    parameter int IDX_BITS = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N_CORES-1:0]    req_valid,
    input  logic [32*N_CORES-1:0] req_addr,
    input  logic [32*N_CORES-1:0] req_wdata,
    input  logic [4*N_CORES-1:0]  req_wstrb,
    output logic [N_CORES-1:0]    req_ready,
    output logic [32*N_CORES-1:0] req_rdata,
    output logic                  m_valid,
    output logic [31:0]           m_addr,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    input  logic                  m_ready,
    input  logic [31:0]           m_rdata,
    output logic [IDX_BITS-1:0]   grant_id,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [1:0]            dbg_state
);

    localparam int TCNT_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_BITS-1:0] TCNT_LAST = TCNT_BITS'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(N_CORES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_BITS-1:0]     r_ptr;
    logic [IDX_BITS-1:0]     r_grant;
    logic [TCNT_BITS-1:0]    r_tcnt;
    logic                    r_m_valid;
    logic [31:0]             r_m_addr;
    logic [31:0]             r_m_wdata;
    logic [3:0]              r_m_wstrb;
    logic [N_CORES-1:0]      r_ready;
    logic [32*N_CORES-1:0]   r_rdata;
    logic                    r_timeout_err;
    logic                    r_busy;

    logic                    w_any;
    logic [IDX_BITS-1:0]     w_win;
    logic                    w_accept;
    logic                    w_abort;

    // Index reached by stepping 'off' places from 'base', wrapping at N_CORES.
    function automatic logic [IDX_BITS-1:0] rot_idx(input logic [IDX_BITS-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= N_CORES) j = j - N_CORES;
        return IDX_BITS'(j);
    endfunction

    // Round-robin winner: scan from the farthest offset down so the requester
    // closest to the pointer overwrites any later one.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (req_valid[rot_idx(r_ptr, i)]) begin
                w_any = 1'b1;
                w_win = rot_idx(r_ptr, i);
            end
        end
    end

    assign w_accept = (r_state == S_ISSUE) && m_ready;
    assign w_abort  = (r_state == S_ISSUE) && !m_ready && (TIMEOUT != 0) && (r_tcnt == TCNT_LAST);

    // Next-state decode for the IDLE -> ISSUE -> RESP cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_accept || w_abort) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Datapath: latch the winner, wait for accept/timeout, then pulse the
    // response into the granted core's slot during the RESP cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr         <= '0;
            r_grant       <= '0;
            r_tcnt        <= '0;
            r_m_valid     <= 1'b0;
            r_m_addr      <= '0;
            r_m_wdata     <= '0;
            r_m_wstrb     <= '0;
            r_ready       <= '0;
            r_rdata       <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_ready       <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_m_valid <= 1'b1;
                        r_m_addr  <= req_addr[32*w_win +: 32];
                        r_m_wdata <= req_wdata[32*w_win +: 32];
                        r_m_wstrb <= req_wstrb[4*w_win +: 4];
                        r_grant   <= w_win;
                        r_tcnt    <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_accept || w_abort) begin
                        // Response registers load here so they are visible
                        // exactly during the RESP cycle.
                        r_m_valid                 <= 1'b0;
                        r_ready[r_grant]          <= 1'b1;
                        r_rdata[32*r_grant +: 32] <= w_accept ? m_rdata : 32'h0;
                        r_timeout_err             <= w_abort;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_ptr <= (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = r_ready;
    assign req_rdata   = r_rdata;
    assign m_valid     = r_m_valid;
    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;
    assign m_wstrb     = r_m_wstrb;
    assign grant_id    = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Testbench for mem_rr_arbiter: directed scenarios followed by randomized
// traffic. A transaction-level model decides, edge by edge, which core wins and
// when the target answers, and pushes expected grants, responses and busy
// values into queues; a monitor pops and compares them as the DUT presents them.
module tb_mem_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 12;

    logic            clk;
    logic            resetn;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_addr;
    logic [32*N-1:0] req_wdata;
    logic [4*N-1:0]  req_wstrb;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_rdata;
    logic            m_valid;
    logic [31:0]     m_addr;
    logic [31:0]     m_wdata;
    logic [3:0]      m_wstrb;
    logic            m_ready;
    logic [31:0]     m_rdata;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            timeout_err;
    logic [1:0]      dbg_state;

    mem_rr_arbiter #(.N_CORES(N), .IDX_BITS(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ready(req_ready), .req_rdata(req_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / counters ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- expectation queues ----------------
    typedef struct {
        int          e;
        int          core;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_item_t;

    typedef struct {
        int          e;
        int          core;
        logic [31:0] rdata;
        logic        abort;
    } rsp_item_t;

    req_item_t exp_req_q[$];
    rsp_item_t exp_rsp_q[$];
    logic      exp_busy_q[$];

    // ---------------- reference model state ----------------
    bit          pend[N];
    logic [31:0] p_addr[N];
    logic [31:0] p_wdata[N];
    logic [3:0]  p_wstrb[N];
    int          lat_q[$];
    logic [31:0] rd_q[$];
    int          rst_pend = 3;
    bit          rnd_en = 0;
    int          ptr = 0;
    int          arb_edge = 0;
    int          acc_edge = 0;
    int          grant_edge = 0;
    int          cur = 0;
    bit          in_issue = 0;
    bit          abort = 0;
    logic [31:0] cur_rd = 32'h0;

    task automatic new_txn(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        pend[k]    = 1'b1;
        p_addr[k]  = a;
        p_wdata[k] = d;
        p_wstrb[k] = s;
    endtask

    function automatic bit any_pend();
        bit r = 1'b0;
        for (int k = 0; k < N; k++) r = r | pend[k];
        return r;
    endfunction

    // Decide what happens at the coming clock edge and drive pins for it.
    task automatic drive_step();
        int          e;
        int          done_core;
        bit          busy_nxt;
        logic        mr;
        logic [31:0] md;
        e         = cyc + 1;
        done_core = -1;
        busy_nxt  = 1'b0;
        mr        = 1'($urandom_range(0, 1));
        md        = $urandom;
        if (rnd_en) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 3) == 0)
                    new_txn(k, $urandom, $urandom,
                            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0);
            end
        end
        if (rst_pend > 0) begin
            rst_pend--;
            resetn   = 1'b0;
            in_issue = 1'b0;
            ptr      = 0;
            arb_edge = e + 1;
        end else begin
            resetn = 1'b1;
            if (in_issue) begin
                busy_nxt = 1'b1;
                if (e == acc_edge) begin
                    rsp_item_t r;
                    mr = !abort;
                    if (!abort) md = cur_rd;
                    r.e     = e;
                    r.core  = cur;
                    r.rdata = abort ? 32'h0 : cur_rd;
                    r.abort = abort;
                    exp_rsp_q.push_back(r);
                    in_issue  = 1'b0;
                    arb_edge  = e + 2;
                    ptr       = (cur + 1) % N;
                    done_core = cur;
                end else begin
                    mr = 1'b0;
                end
            end else if (e >= arb_edge) begin
                int w = -1;
                for (int i = N - 1; i >= 0; i--)
                    if (pend[(ptr + i) % N]) w = (ptr + i) % N;
                if (w >= 0) begin
                    req_item_t q;
                    int        lat;
                    cur        = w;
                    grant_edge = e;
                    in_issue   = 1'b1;
                    busy_nxt   = 1'b1;
                    q.e     = e;
                    q.core  = w;
                    q.addr  = p_addr[w];
                    q.wdata = p_wdata[w];
                    q.wstrb = p_wstrb[w];
                    exp_req_q.push_back(q);
                    if (lat_q.size() > 0) lat = lat_q.pop_front();
                    else if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(TO - 1, TO + 2));
                    else lat = int'($urandom_range(0, 3));
                    cur_rd = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
                    if (lat < TO) begin
                        acc_edge = e + 1 + lat;
                        abort    = 1'b0;
                    end else begin
                        acc_edge = e + TO;
                        abort    = 1'b1;
                    end
                end
            end
        end
        exp_busy_q.push_back(busy_nxt);
        for (int k = 0; k < N; k++) begin
            req_valid[k]          = pend[k];
            req_addr[32*k +: 32]  = p_addr[k];
            req_wdata[32*k +: 32] = p_wdata[k];
            req_wstrb[4*k +: 4]   = p_wstrb[k];
        end
        // Granted core may misbehave and drop its request early.
        if (rnd_en && in_issue && e > grant_edge && $urandom_range(0, 3) == 0)
            req_valid[cur] = 1'b0;
        if (done_core >= 0) pend[done_core] = 1'b0;
        m_ready = mr;
        m_rdata = md;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k]    = 1'b0;
            p_addr[k]  = 32'h0;
            p_wdata[k] = 32'h0;
            p_wstrb[k] = 4'h0;
        end
        #1;
        drive_step();
        forever begin
            @(negedge clk);
            drive_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] exp_rdata[N];
    bit          prev_mv = 1'b0;
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_wstrb;
    req_item_t   mon_req;
    rsp_item_t   mon_rsp;
    logic [N-1:0] exp_oh;

    initial for (int k = 0; k < N; k++) exp_rdata[k] = 32'h0;

    always @(posedge clk) begin
        #1;
        if (exp_busy_q.size() == 0) check("busy_q_empty", 1, 0);
        else check("busy", busy, exp_busy_q.pop_front());
        if (!resetn) begin
            for (int k = 0; k < N; k++) exp_rdata[k] = 32'h0;
            check("rst_m_valid", m_valid, 0);
            check("rst_req_ready", req_ready, 0);
            check("rst_grant_id", grant_id, 0);
            check("rst_timeout_err", timeout_err, 0);
            check("rst_m_addr", m_addr, 0);
            check("rst_state", dbg_state, 0);
            prev_mv = 1'b0;
        end else begin
            if (m_valid && !prev_mv) begin
                if (exp_req_q.size() == 0) begin
                    check("unexpected_m_valid", 1, 0);
                end else begin
                    mon_req = exp_req_q.pop_front();
                    check("grant_cycle", cyc, mon_req.e);
                    check("grant_id", grant_id, mon_req.core);
                    check("m_addr", m_addr, mon_req.addr);
                    check("m_wdata", m_wdata, mon_req.wdata);
                    check("m_wstrb", m_wstrb, mon_req.wstrb);
                end
                hold_addr  = m_addr;
                hold_wdata = m_wdata;
                hold_wstrb = m_wstrb;
            end else if (m_valid) begin
                check("m_addr_stable", m_addr, hold_addr);
                check("m_wdata_stable", m_wdata, hold_wdata);
                check("m_wstrb_stable", m_wstrb, hold_wstrb);
            end
            prev_mv = m_valid;
            if (req_ready != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    check("unexpected_req_ready", req_ready, 0);
                end else begin
                    mon_rsp = exp_rsp_q.pop_front();
                    exp_oh = '0;
                    exp_oh[mon_rsp.core] = 1'b1;
                    check("ready_cycle", cyc, mon_rsp.e);
                    check("req_ready", req_ready, exp_oh);
                    check("timeout_err", timeout_err, mon_rsp.abort);
                    exp_rdata[mon_rsp.core] = mon_rsp.rdata;
                end
            end else begin
                check("timeout_err_idle", timeout_err, 0);
            end
            for (int k = 0; k < N; k++)
                check($sformatf("req_rdata[%0d]", k), req_rdata[32*k +: 32], exp_rdata[k]);
        end
    end

    // ---------------- directed + random sequence ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((in_issue || any_pend()) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) check("idle_wait_expired", 1, 0);
        wait_cycles(3);
    endtask

    initial begin
        wait_cycles(6);

        // Single read by core 2, immediate accept.
        lat_q.push_back(0);
        rd_q.push_back(32'hCAFE_F00D);
        new_txn(2, 32'h0000_0100, 32'h0, 4'h0);
        wait_idle();

        // Fresh reset, then all four at once: rotation 0,1,2,3.
        rst_pend = 1;
        wait_cycles(2);
        for (int k = 0; k < N; k++) begin
            lat_q.push_back(0);
            new_txn(k, 32'h4000_0000 + 32'(k), 32'h1111_0000 + 32'(k), 4'h0);
        end
        wait_idle();

        // Pointer back at 0: cores 0 and 3 -> 0 first, then 3.
        new_txn(0, 32'h0000_0040, 32'h0, 4'h0);
        new_txn(3, 32'h0000_0080, 32'hABCD_0003, 4'hF);
        wait_idle();

        // Core 1 write with a slow target (10 wait cycles, below timeout).
        lat_q.push_back(10);
        new_txn(1, 32'h1000_0000, 32'h0100_0001, 4'b0101);
        wait_idle();

        // Target never answers: abort after TO cycles with zero data.
        lat_q.push_back(TO + 5);
        new_txn(0, 32'h2000_0000, 32'h0, 4'h0);
        wait_idle();

        // Reset while core 3 is in flight; cores 1 and 3 then retry from ptr 0.
        lat_q.push_back(8);
        new_txn(3, 32'h3000_0000, 32'h0, 4'h0);
        wait_cycles(4);
        rst_pend = 1;
        new_txn(1, 32'h3000_0004, 32'h0, 4'h0);
        wait_idle();

        // Randomized traffic with random target latency, ignored m_ready
        // pulses and early request drops by the granted core.
        rnd_en = 1'b1;
        wait_cycles(3000);
        rnd_en = 1'b0;
        wait_idle();

        check("req_q_left", exp_req_q.size(), 0);
        check("rsp_q_left", exp_rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
